pc_fetch_ctrl: RTL and testbench
================================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 16'h0000: PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 instr  input  16  instruction at current pc, from instruction memory; [15:12] opcode, [11:9] ccc, [8:0] imm9.
REQ-005 flag_z / flag_v / flag_n  input  1 each  current flag-register outputs.
REQ-006 br_target  input  16  register-file read data for the BR source register.
REQ-007 stall  input  1  hold request; PC and state frozen while high.
REQ-008 pc  output  16  address of the instruction being fetched (registered).
REQ-009 pc_plus2  output  16  pc + 2, combinational; write data for PCS.
REQ-010 fetch_en  output  1  instruction-memory read enable; high only in RUN with stall low.
REQ-011 hlt  output  1  registered; high once HALT is entered.

Function
REQ-012 States: RUN, HALT; reset enters RUN.
REQ-013 RUN, stall low, opcode not 1100/1101/1111: pc <= pc + 2 next edge.
REQ-014 Opcode 1100 (B), condition true: pc <= pc + 2 + (sext(imm9) << 1); condition false: pc <= pc + 2.
REQ-015 Opcode 1101 (BR), condition true: pc <= br_target; condition false: pc <= pc + 2.
REQ-016 Conditions on ccc: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
REQ-017 Opcode 1110 (PCS): pc <= pc + 2; pc_plus2 is the value written.
REQ-018 Opcode 1111 (HLT) in RUN, stall low: pc holds; state -> HALT; hlt high from next edge.
REQ-019 HALT: pc, hlt frozen; fetch_en low; exited only by reset.
REQ-020 stall high: pc and state hold, including when HLT or branch present; decision taken on the first edge with stall low.
REQ-021 All address arithmetic 16-bit modulo 2^16; 16'hFFFE + 2 = 16'h0000; backward branches wrap likewise.
REQ-022 Branch target bit 0 always 0 for B; BR uses br_target unmodified.
REQ-023 Zero-cycle decision: next-pc is combinational on instr/flags of the current cycle; one-edge latency to pc.

Reset
REQ-024 rst_n low at an edge: pc <= RESET_VECTOR, state <= RUN, hlt <= 0; dominates stall and HALT.
REQ-025 Reset mid-stall or in HALT restarts fetch at RESET_VECTOR on the first edge after rst_n rises.
REQ-026 While rst_n low, fetch_en low.

Structure
REQ-027 Shared package wisc_pkg holds opcode constants (B, BR, PCS, HLT), ccc encodings, and the state enum.
REQ-028 One sub-module branch_cond: combinational, ccc + Z/V/N -> taken.
REQ-029 PC register and state register in pc_fetch_ctrl only; no memory instance inside.

Verification
REQ-030 Reset then 4 NOPs (instr=16'h0000, opcode ADD): pc 0000 -> 0002 -> 0004 -> 0006 -> 0008; hlt=0.
REQ-031 pc=0010, instr B ccc=001 imm9=9'h1FE, Z=1: next pc=000E; same with Z=0: next pc=0012.
REQ-032 pc=0020, instr BR ccc=111, br_target=1234: next pc=1234; ccc=110, V=0: next pc=0022.
REQ-033 pc=0040, HLT with stall high for 3 cycles: pc=0040, hlt=0 throughout; stall low: hlt=1 next edge, pc stays 0040, fetch_en=0.
REQ-034 In HALT, rst_n low one edge with RESET_VECTOR=16'h0100: pc=0100, hlt=0, fetch_en=1 after release.
REQ-035 pc=FFFE, NOP: next pc=0000; pc_plus2 at FFFE reads 0000.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared definitions for the fetch controller: opcodes, condition codes and FSM states.
package wisc_pkg;

  localparam logic [3:0] OpB   = 4'b1100;
  localparam logic [3:0] OpBr  = 4'b1101;
  localparam logic [3:0] OpPcs = 4'b1110;
  localparam logic [3:0] OpHlt = 4'b1111;

  localparam logic [2:0] CccNe  = 3'b000;
  localparam logic [2:0] CccEq  = 3'b001;
  localparam logic [2:0] CccGt  = 3'b010;
  localparam logic [2:0] CccLt  = 3'b011;
  localparam logic [2:0] CccGe  = 3'b100;
  localparam logic [2:0] CccLe  = 3'b101;
  localparam logic [2:0] CccOvf = 3'b110;
  localparam logic [2:0] CccUnc = 3'b111;

  typedef enum logic {
    StRun,
    StHalt
  } fetch_state_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: maps a condition code and the Z/V/N flags to taken.
module branch_cond
  import wisc_pkg::*;
(
  input  logic [2:0] ccc_i,
  input  logic       flag_z_i,
  input  logic       flag_v_i,
  input  logic       flag_n_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (ccc_i)
      CccNe:   taken_o = ~flag_z_i;
      CccEq:   taken_o = flag_z_i;
      CccGt:   taken_o = ~flag_z_i & ~flag_n_i;
      CccLt:   taken_o = flag_n_i;
      CccGe:   taken_o = flag_z_i | (~flag_z_i & ~flag_n_i);
      CccLe:   taken_o = flag_n_i | flag_z_i;
      CccOvf:  taken_o = flag_v_i;
      CccUnc:  taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch control: sequential fetch, B/BR branches, PCS and HLT.
module pc_fetch_ctrl
  import wisc_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        flag_z,
  input  logic        flag_v,
  input  logic        flag_n,
  input  logic [15:0] br_target,
  input  logic        stall,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        fetch_en,
  output logic        hlt
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic         hlt_q, hlt_d;
  logic         taken;
  logic [3:0]   opcode;
  logic [15:0]  br_offset;

  assign opcode    = instr[15:12];
  // Sign-extended imm9 scaled to a halfword offset; bit 0 is always zero.
  assign br_offset = {{6{instr[8]}}, instr[8:0], 1'b0};

  branch_cond u_branch_cond (
    .ccc_i   (instr[11:9]),
    .flag_z_i(flag_z),
    .flag_v_i(flag_v),
    .flag_n_i(flag_n),
    .taken_o (taken)
  );

  always_comb begin
    pc_plus2 = pc_q + 16'd2;
    pc_d     = pc_q;
    state_d  = state_q;
    hlt_d    = hlt_q;
    if (state_q == StRun && !stall) begin
      case (opcode)
        OpB:     pc_d = taken ? (pc_plus2 + br_offset) : pc_plus2;
        OpBr:    pc_d = taken ? br_target : pc_plus2;
        OpHlt: begin
          state_d = StHalt;
          hlt_d   = 1'b1;
        end
        default: pc_d = pc_plus2;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_VECTOR;
      state_q <= StRun;
      hlt_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      hlt_q   <= hlt_d;
    end
  end

  assign pc       = pc_q;
  assign hlt      = hlt_q;
  assign fetch_en = rst_n & ~stall & (state_q == StRun);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl, with a second instance at RESET_VECTOR 0100.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        flag_z, flag_v, flag_n;
  logic [15:0] br_target;
  logic        stall;

  logic [15:0] pc0, pc_plus2_0, pc1, pc_plus2_1;
  logic        fetch_en0, hlt0, fetch_en1, hlt1;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_pc;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (instr),
    .flag_z   (flag_z),
    .flag_v   (flag_v),
    .flag_n   (flag_n),
    .br_target(br_target),
    .stall    (stall),
    .pc       (pc0),
    .pc_plus2 (pc_plus2_0),
    .fetch_en (fetch_en0),
    .hlt      (hlt0)
  );

  pc_fetch_ctrl #(.RESET_VECTOR(16'h0100)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (instr),
    .flag_z   (flag_z),
    .flag_v   (flag_v),
    .flag_n   (flag_n),
    .br_target(br_target),
    .stall    (stall),
    .pc       (pc1),
    .pc_plus2 (pc_plus2_1),
    .fetch_en (fetch_en1),
    .hlt      (hlt1)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Unconditional BR to an absolute address, used to position the PC.
  task automatic jump(input logic [15:0] addr);
    instr     = 16'hDE00;
    br_target = addr;
    step();
    check("jump", pc0, addr);
  endtask

  // BR with target 0100: taken lands there, not taken falls through.
  task automatic cond_step(input string tag, input logic [2:0] ccc, input logic z,
                           input logic v, input logic n, input logic taken_exp);
    instr     = {4'b1101, ccc, 9'h000};
    br_target = 16'h0100;
    flag_z    = z;
    flag_v    = v;
    flag_n    = n;
    exp_pc    = taken_exp ? 16'h0100 : exp_pc + 16'd2;
    step();
    check(tag, pc0, exp_pc);
  endtask

  initial begin
    rst_n     = 1'b0;
    instr     = 16'h0000;
    flag_z    = 1'b0;
    flag_v    = 1'b0;
    flag_n    = 1'b0;
    br_target = 16'h0000;
    stall     = 1'b0;

    step();
    step();
    check("rst_pc", pc0, 16'h0000);
    check("rst_pc_rv", pc1, 16'h0100);
    check("rst_hlt", {15'b0, hlt0}, 16'h0000);
    check("rst_fetch_en", {15'b0, fetch_en0}, 16'h0000);

    rst_n = 1'b1;
    #1;
    check("run_fetch_en", {15'b0, fetch_en0}, 16'h0001);
    check("pc_plus2_0", pc_plus2_0, 16'h0002);
    step(); check("nop1", pc0, 16'h0002);
    step(); check("nop2", pc0, 16'h0004);
    step(); check("nop3", pc0, 16'h0006);
    step(); check("nop4", pc0, 16'h0008);
    check("nop_hlt", {15'b0, hlt0}, 16'h0000);

    // B ccc=001 imm9=-2
    jump(16'h0010);
    instr  = 16'hC3FE;
    flag_z = 1'b1;
    step(); check("b_taken", pc0, 16'h000E);
    jump(16'h0010);
    instr  = 16'hC3FE;
    flag_z = 1'b0;
    step(); check("b_not_taken", pc0, 16'h0012);

    jump(16'h0020);
    instr = 16'hDE00; br_target = 16'h1234;
    step(); check("br_taken", pc0, 16'h1234);
    jump(16'h0020);
    instr = 16'hDC00; br_target = 16'h1234; flag_v = 1'b0;
    step(); check("br_v0", pc0, 16'h0022);

    exp_pc = 16'h0022;
    cond_step("ccc000_z0", 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    cond_step("ccc000_z1", 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    cond_step("ccc001_z0", 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    cond_step("ccc010_t",  3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
    cond_step("ccc010_n1", 3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
    cond_step("ccc011_n1", 3'b011, 1'b0, 1'b0, 1'b1, 1'b1);
    cond_step("ccc100_n1", 3'b100, 1'b0, 1'b0, 1'b1, 1'b0);
    cond_step("ccc100_z1", 3'b100, 1'b1, 1'b0, 1'b1, 1'b1);
    cond_step("ccc101_f",  3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
    cond_step("ccc101_n1", 3'b101, 1'b0, 1'b0, 1'b1, 1'b1);
    cond_step("ccc110_v1", 3'b110, 1'b0, 1'b1, 1'b0, 1'b1);
    cond_step("ccc111_un", 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);

    // PCS just advances; pc_plus2 carries the link value.
    jump(16'h0300);
    instr = 16'hE000;
    #1;
    check("pcs_link", pc_plus2_0, 16'h0302);
    step(); check("pcs_pc", pc0, 16'h0302);

    jump(16'hFFFE);
    instr = 16'h0000;
    #1;
    check("wrap_plus2", pc_plus2_0, 16'h0000);
    step(); check("wrap_pc", pc0, 16'h0000);
    instr = 16'hCFFE;
    step(); check("b_back_wrap", pc0, 16'hFFFE);

    // Branch held by stall, resolved on the first unstalled edge.
    jump(16'h0050);
    instr = 16'hDE00; br_target = 16'h0777; stall = 1'b1;
    step(); check("stall_br", pc0, 16'h0050);
    stall = 1'b0;
    step(); check("stall_br_rel", pc0, 16'h0777);

    jump(16'h0040);
    instr = 16'hF000;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hlt_stall_pc", pc0, 16'h0040);
      check("hlt_stall_hlt", {15'b0, hlt0}, 16'h0000);
      check("hlt_stall_fe", {15'b0, fetch_en0}, 16'h0000);
    end
    stall = 1'b0;
    #1;
    check("hlt_pre_fe", {15'b0, fetch_en0}, 16'h0001);
    step();
    check("hlt_hlt", {15'b0, hlt0}, 16'h0001);
    check("hlt_pc", pc0, 16'h0040);
    check("hlt_fe", {15'b0, fetch_en0}, 16'h0000);
    instr = 16'hDE00; br_target = 16'h0999;
    step(); step();
    check("halt_frozen_pc", pc0, 16'h0040);
    check("halt_frozen_hlt", {15'b0, hlt0}, 16'h0001);
    check("halt_rv_hlt", {15'b0, hlt1}, 16'h0001);

    rst_n = 1'b0;
    instr = 16'h0000;
    step();
    check("halt_rst_pc", pc0, 16'h0000);
    check("halt_rst_pc_rv", pc1, 16'h0100);
    check("halt_rst_hlt", {15'b0, hlt1}, 16'h0000);
    check("halt_rst_fe", {15'b0, fetch_en1}, 16'h0000);
    rst_n = 1'b1;
    #1;
    check("rel_fe_rv", {15'b0, fetch_en1}, 16'h0001);
    step();
    check("rel_pc_rv", pc1, 16'h0102);

    // Reset dominates stall.
    stall = 1'b1;
    rst_n = 1'b0;
    step();
    check("stall_rst_pc", pc1, 16'h0100);
    rst_n = 1'b1;
    stall = 1'b0;
    step();
    check("stall_rst_run", pc1, 16'h0102);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
